// File: rtl/su_cfg_pkg.sv
// Shared constants and state type for the switch-unit configuration controller.
package su_cfg_pkg;

  localparam int SU_DIR_W   = 6;
  localparam int CFG_WORD_W = 8;

  localparam int DIR_LSB  = 0;
  localparam int RSVD_BIT = 6;
  localparam int PAR_BIT  = 7;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    DRAIN  = 2'd2,
    COMMIT = 2'd3
  } su_cfg_state_t;

endpackage

// File: rtl/su_cfg_word_chk.sv
// Combinational check of one host configuration word.
// Bit-7 even-parity checking is compiled in only when SU_CFG_PARITY_EN is defined.
module su_cfg_word_chk
  import su_cfg_pkg::*;
(
  input  logic [CFG_WORD_W-1:0] word,
  output logic                  word_ok,
  output logic [SU_DIR_W-1:0]   dir
);

  assign dir = word[DIR_LSB +: SU_DIR_W];

`ifdef SU_CFG_PARITY_EN
  // Even parity over [6:0] stored in bit 7 means the whole word XORs to zero.
  assign word_ok = !word[RSVD_BIT] && !(^word);
`else
  logic unused_par;
  assign unused_par = word[PAR_BIT];
  assign word_ok    = !word[RSVD_BIT];
`endif

endmodule

// File: rtl/su_cfg_ctrl.sv
// Loads per-SU routing words into shadow registers and commits them atomically.
// Optional build macro: SU_CFG_PARITY_EN (enables bit-7 parity checking).
module su_cfg_ctrl
  import su_cfg_pkg::*;
#(
  parameter int N_SU  = 8,
  parameter int IDX_W = (N_SU > 1) ? $clog2(N_SU) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cfg_start,
  input  logic                         cfg_abort,
  input  logic                         cfg_valid,
  input  logic [CFG_WORD_W-1:0]        cfg_data,
  output logic                         cfg_ready,
  output logic                         busy,
  output logic                         cfg_done,
  output logic                         cfg_err,
  output logic [N_SU*SU_DIR_W-1:0]     dir_con_out
);

  su_cfg_state_t state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic err_q, err_d;
  logic done_q;
  logic [SU_DIR_W-1:0] shadow_q [N_SU];
  logic [N_SU*SU_DIR_W-1:0] active_q;

  logic word_ok;
  logic [SU_DIR_W-1:0] word_dir;
  logic xfer, last, shadow_we;

  su_cfg_word_chk u_word_chk (
    .word    (cfg_data),
    .word_ok (word_ok),
    .dir     (word_dir)
  );

  assign cfg_ready   = ((state_q == LOAD) || (state_q == DRAIN)) && !cfg_abort;
  assign xfer        = cfg_ready && cfg_valid;
  assign last        = (idx_q == IDX_W'(N_SU - 1));
  assign busy        = (state_q != IDLE);
  assign cfg_done    = done_q;
  assign cfg_err     = err_q;
  assign dir_con_out = active_q;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    err_d     = err_q;
    shadow_we = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cfg_start) begin
          state_d = LOAD;
          idx_d   = '0;
          err_d   = 1'b0;
        end
      end
      LOAD: begin
        if (cfg_abort) begin
          state_d = IDLE;
        end else if (xfer) begin
          idx_d = idx_q + 1'b1;
          if (word_ok) begin
            shadow_we = 1'b1;
            if (last) state_d = COMMIT;
          end else begin
            // A bad final word has nothing left to drain.
            err_d   = 1'b1;
            state_d = last ? IDLE : DRAIN;
          end
        end
      end
      DRAIN: begin
        if (cfg_abort) begin
          state_d = IDLE;
        end else if (xfer) begin
          idx_d = idx_q + 1'b1;
          if (last) state_d = IDLE;
        end
      end
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
      active_q <= '0;
      for (int i = 0; i < N_SU; i++) shadow_q[i] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      done_q  <= (state_q == COMMIT);
      if (shadow_we) shadow_q[idx_q] <= word_dir;
      if (state_q == COMMIT) begin
        for (int i = 0; i < N_SU; i++) active_q[i*SU_DIR_W +: SU_DIR_W] <= shadow_q[i];
      end
    end
  end

endmodule
